// File: rtl/counter_nch_if.sv
// Bus bundle between the CPU-side MIO decode and the multi-channel counter.
interface counter_nch_if #(
  parameter int unsigned NCH   = 3,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CH_W  = 2
);
  logic [NCH-1:0]   tick;
  logic             we;
  logic [CH_W-1:0]  ch;
  logic             reg_sel;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             cnt_out;
  logic [NCH-1:0]   ch_out;
  logic [NCH-1:0]   irq;

  // CPU / bus side
  modport master (
    output tick, we, ch, reg_sel, wdata,
    input  rdata, cnt_out, ch_out, irq
  );

  // Counter side
  modport slave (
    input  tick, we, ch, reg_sel, wdata,
    output rdata, cnt_out, ch_out, irq
  );
endinterface

// File: rtl/counter_nch.sv
// Parametrised multi-channel down-counter/timer with one-shot, auto-reload
// and square-wave modes, maskable per-channel interrupts and combinational
// register readback.
module counter_nch #(
  parameter int unsigned NCH   = 3,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CH_W  = 2
) (
  input  logic          clk,
  input  logic          rst,
  counter_nch_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_OFF = 2'b00,
    MODE_ONE = 2'b01,
    MODE_AR  = 2'b10,
    MODE_SQ  = 2'b11
  } mode_e;

  // Per-channel architectural state
  logic [WIDTH-1:0] r_load  [NCH];
  logic [WIDTH-1:0] r_count [NCH];
  mode_e            r_mode  [NCH];
  logic [NCH-1:0]   r_ien;
  logic [NCH-1:0]   r_flag;
  logic [NCH-1:0]   r_armed;
  logic [NCH-1:0]   r_out;

  // Next-state values
  logic [WIDTH-1:0] w_load_nxt  [NCH];
  logic [WIDTH-1:0] w_count_nxt [NCH];
  mode_e            w_mode_nxt  [NCH];
  logic [NCH-1:0]   w_ien_nxt;
  logic [NCH-1:0]   w_flag_nxt;
  logic [NCH-1:0]   w_armed_nxt;
  logic [NCH-1:0]   w_out_nxt;

  // Per-channel decode of writes, ticks and terminal events
  logic [NCH-1:0]   w_ld_wr;
  logic [NCH-1:0]   w_ctl_wr;
  logic [NCH-1:0]   w_kill;
  logic [NCH-1:0]   w_fire;
  logic [NCH-1:0]   w_term;
  logic [WIDTH-1:0] w_rdata;

  // Decode which channel is written and which channels see a live tick
  always_comb begin
    w_ld_wr  = '0;
    w_ctl_wr = '0;
    w_term   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.we && (bus.ch == CH_W'(i))) begin
        w_ld_wr[i]  = ~bus.reg_sel;
        w_ctl_wr[i] = bus.reg_sel;
      end
    end
    // A CTRL write to mode OFF disarms and beats a same-cycle tick
    w_kill = w_ctl_wr & {NCH{bus.wdata[1:0] == 2'b00}};
    // A LOAD write discards a same-cycle tick
    w_fire = r_armed & bus.tick & ~w_ld_wr;
    for (int i = 0; i < NCH; i++) begin
      w_term[i] = w_fire[i] && (r_count[i] == WIDTH'(1));
    end
  end

  // Next-state for every channel: write, disarm, count step, CTRL, flag
  always_comb begin
    w_ien_nxt   = r_ien;
    w_flag_nxt  = r_flag;
    w_armed_nxt = r_armed;
    w_out_nxt   = r_out;
    for (int i = 0; i < NCH; i++) begin
      w_load_nxt[i]  = r_load[i];
      w_count_nxt[i] = r_count[i];
      w_mode_nxt[i]  = r_mode[i];
      // Auto-reload output is a single-cycle pulse
      if (r_mode[i] == MODE_AR) begin
        w_out_nxt[i] = 1'b0;
      end

      if (w_ld_wr[i]) begin
        w_load_nxt[i]  = bus.wdata;
        w_count_nxt[i] = bus.wdata;
        w_armed_nxt[i] = (bus.wdata != '0) && (r_mode[i] != MODE_OFF);
        if (r_mode[i] == MODE_ONE) begin
          w_out_nxt[i] = (bus.wdata != '0);
        end
      end else if (w_kill[i]) begin
        w_armed_nxt[i] = 1'b0;
        w_out_nxt[i]   = 1'b0;
      end else if (w_fire[i]) begin
        if (w_term[i]) begin
          unique case (r_mode[i])
            MODE_AR: begin
              w_count_nxt[i] = r_load[i];
              w_out_nxt[i]   = 1'b1;
            end
            MODE_SQ: begin
              w_count_nxt[i] = r_load[i];
              w_out_nxt[i]   = ~r_out[i];
            end
            default: begin
              w_count_nxt[i] = '0;
              w_armed_nxt[i] = 1'b0;
              w_out_nxt[i]   = 1'b0;
            end
          endcase
        end else begin
          w_count_nxt[i] = r_count[i] - WIDTH'(1);
        end
      end

      if (w_ctl_wr[i]) begin
        w_mode_nxt[i] = mode_e'(bus.wdata[1:0]);
        w_ien_nxt[i]  = bus.wdata[2];
        if (bus.wdata[3]) begin
          w_flag_nxt[i] = 1'b0;
        end
      end
      // Event set beats a same-cycle W1C clear
      if (w_term[i]) begin
        w_flag_nxt[i] = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_load[i]  <= '0;
        r_count[i] <= '0;
        r_mode[i]  <= MODE_OFF;
      end
      r_ien   <= '0;
      r_flag  <= '0;
      r_armed <= '0;
      r_out   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_load[i]  <= w_load_nxt[i];
        r_count[i] <= w_count_nxt[i];
        r_mode[i]  <= w_mode_nxt[i];
      end
      r_ien   <= w_ien_nxt;
      r_flag  <= w_flag_nxt;
      r_armed <= w_armed_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // Combinational readback; unimplemented channels read as zero
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.ch == CH_W'(i)) begin
        if (bus.reg_sel) begin
          w_rdata = WIDTH'({r_armed[i], r_out[i], r_flag[i], r_ien[i],
                            2'(r_mode[i])});
        end else begin
          w_rdata = r_count[i];
        end
      end
    end
  end

  assign bus.rdata   = w_rdata;
  assign bus.ch_out  = r_out;
  assign bus.cnt_out = r_out[0];
  assign bus.irq     = r_flag & r_ien;

endmodule

// File: tb/tb_counter_nch.sv
// Bench for counter_nch: directed scenarios plus random traffic checked
// against a behavioural per-channel timer model.
module tb_counter_nch;

  localparam int unsigned NCH   = 5;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned CH_W  = 3;

  logic clk;
  logic rst;

  counter_nch_if #(.NCH(NCH), .WIDTH(WIDTH), .CH_W(CH_W)) bus ();

  counter_nch #(.NCH(NCH), .WIDTH(WIDTH), .CH_W(CH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: one record of timer state per channel
  int unsigned m_load  [NCH];
  int unsigned m_count [NCH];
  int unsigned m_mode  [NCH];
  bit          m_ien   [NCH];
  bit          m_flag  [NCH];
  bit          m_armed [NCH];
  bit          m_out   [NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_load[i] = 0; m_count[i] = 0; m_mode[i] = 0;
      m_ien[i] = 0; m_flag[i] = 0; m_armed[i] = 0; m_out[i] = 0;
    end
  endtask

  // Advance the model by one clock edge given the inputs present at that edge
  task automatic model_step(input logic [NCH-1:0] t, input bit w, input int c,
                            input bit rs, input int unsigned d);
    for (int i = 0; i < NCH; i++) begin
      bit ldw, ctw, live, ev, stop;
      ldw  = w && (c == i) && !rs;
      ctw  = w && (c == i) && rs;
      live = m_armed[i] && t[i] && !ldw;
      ev   = live && (m_count[i] == 1);
      stop = ctw && ((d % 4) == 0);
      if (m_mode[i] == 2) m_out[i] = 0;
      if (ldw) begin
        m_load[i]  = d;
        m_count[i] = d;
        m_armed[i] = (d != 0) && (m_mode[i] != 0);
        if (m_mode[i] == 1) m_out[i] = m_armed[i];
      end else if (stop) begin
        m_armed[i] = 0;
        m_out[i]   = 0;
      end else if (live) begin
        if (!ev) m_count[i] = m_count[i] - 1;
        else if (m_mode[i] == 2) begin m_count[i] = m_load[i]; m_out[i] = 1; end
        else if (m_mode[i] == 3) begin m_count[i] = m_load[i]; m_out[i] = !m_out[i]; end
        else begin m_count[i] = 0; m_armed[i] = 0; m_out[i] = 0; end
      end
      if (ctw) begin
        m_mode[i] = d % 4;
        m_ien[i]  = ((d / 4) % 2) == 1;
        if (((d / 8) % 2) == 1) m_flag[i] = 0;
      end
      if (ev) m_flag[i] = 1;
    end
  endtask

  function automatic int unsigned model_rdata(input int c, input bit rs);
    if (c >= NCH) return 0;
    if (!rs) return m_count[c];
    return (32'(m_armed[c]) << 5) | (32'(m_out[c]) << 4) | (32'(m_flag[c]) << 3) |
           (32'(m_ien[c]) << 2) | m_mode[c];
  endfunction

  task automatic check_outputs(input int c, input bit rs);
    logic [NCH-1:0] e_out, e_irq;
    for (int i = 0; i < NCH; i++) begin
      e_out[i] = m_out[i];
      e_irq[i] = m_flag[i] & m_ien[i];
    end
    check("ch_out", 32'(bus.ch_out), 32'(e_out));
    check("irq", 32'(bus.irq), 32'(e_irq));
    check("cnt_out", 32'(bus.cnt_out), 32'(m_out[0]));
    check("rdata", 32'(bus.rdata), model_rdata(c, rs));
  endtask

  // One clock: drive at negedge, compare outputs with the model, model the edge
  task automatic cycle(input logic [NCH-1:0] t, input bit w, input int c,
                       input bit rs, input int unsigned d);
    @(negedge clk);
    bus.tick    = t;
    bus.we      = w;
    bus.ch      = CH_W'(c);
    bus.reg_sel = rs;
    bus.wdata   = WIDTH'(d);
    #1;
    check_outputs(c, rs);
    @(posedge clk);
    model_step(t, w, c, rs, d);
  endtask

  task automatic wr(input int c, input bit rs, input int unsigned d);
    cycle('0, 1'b1, c, rs, d);
  endtask

  // Read a register between the edge just taken and the next negedge
  task automatic peek(input int c, input bit rs, output logic [31:0] v);
    #1;
    bus.we      = 1'b0;
    bus.tick    = '0;
    bus.ch      = CH_W'(c);
    bus.reg_sel = rs;
    #1;
    v = 32'(bus.rdata);
  endtask

  initial begin
    logic [31:0] v;
    int          pulses;
    int          c, rsel;
    int unsigned d;
    bit          w;

    bus.tick = '0; bus.we = 1'b0; bus.ch = '0; bus.reg_sel = 1'b0; bus.wdata = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_irq", 32'(bus.irq), 32'h0);
    check("rst_ch_out", 32'(bus.ch_out), 32'h0);
    for (int i = 0; i < NCH; i++) cycle('0, 1'b0, i, 1'b1, 0);

    // One-shot on ch1
    wr(1, 1'b1, 5);
    wr(1, 1'b0, 3);
    peek(1, 1'b0, v);
    check("os_cnt_load", v, 32'd3);
    check("os_out_armed", 32'(bus.ch_out[1]), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      cycle(NCH'(2), 1'b0, 1, 1'b0, 0);
      peek(1, 1'b0, v);
      check("os_cnt", v, 32'(3 - k));
      check("os_out", 32'(bus.ch_out[1]), (k < 3) ? 32'd1 : 32'd0);
      check("os_irq", 32'(bus.irq[1]), (k == 3) ? 32'd1 : 32'd0);
    end
    cycle(NCH'(2), 1'b0, 1, 1'b0, 0);
    peek(1, 1'b0, v);
    check("os_no_wrap", v, 32'd0);

    // Auto-reload on ch0 with a tick every cycle
    wr(0, 1'b1, 6);
    wr(0, 1'b0, 4);
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle(NCH'(1), 1'b0, 0, 1'b0, 0);
      peek(0, 1'b0, v);
      check("ar_cnt", v, ((k % 4) == 0) ? 32'd4 : 32'(4 - (k % 4)));
      check("ar_pulse", 32'(bus.cnt_out), ((k % 4) == 0) ? 32'd1 : 32'd0);
      if (bus.cnt_out) pulses++;
    end
    check("ar_npulse", 32'(pulses), 32'd3);

    // Square wave on ch2
    wr(2, 1'b1, 7);
    wr(2, 1'b0, 2);
    for (int k = 1; k <= 8; k++) begin
      cycle(NCH'(4), 1'b0, 2, 1'b0, 0);
      peek(2, 1'b1, v);
      check("sq_out", 32'(bus.ch_out[2]), 32'((k / 2) % 2));
      check("sq_flag", 32'(v[3]), (k >= 2) ? 32'd1 : 32'd0);
    end

    // Collision: LOAD write with a tick on the same channel
    cycle(NCH'(1), 1'b1, 0, 1'b0, 7);
    peek(0, 1'b0, v);
    check("col_load_wins", v, 32'd7);

    // Collision: W1C together with a terminal event
    wr(1, 1'b1, 13);
    peek(1, 1'b1, v);
    check("w1c_clear", 32'(v[3]), 32'd0);
    wr(1, 1'b0, 2);
    cycle(NCH'(2), 1'b0, 1, 1'b0, 0);
    cycle(NCH'(2), 1'b1, 1, 1'b1, 13);
    peek(1, 1'b1, v);
    check("col_flag_set_wins", 32'(v[3]), 32'd1);
    check("col_irq", 32'(bus.irq[1]), 32'd1);

    // Full-width load on ch4, writes/reads beyond NCH
    wr(4, 1'b1, 2);
    wr(4, 1'b0, 32'hFFFF);
    peek(4, 1'b0, v);
    check("ch4_load", v, 32'hFFFF);
    repeat (3) cycle(NCH'(16), 1'b0, 4, 1'b0, 0);
    peek(4, 1'b0, v);
    check("ch4_count", v, 32'hFFFC);
    wr(6, 1'b0, 32'h1234);
    peek(6, 1'b0, v);
    check("ch6_count", v, 32'h0);
    peek(6, 1'b1, v);
    check("ch6_status", v, 32'h0);
    cycle('0, 1'b0, 4, 1'b0, 0);
    peek(4, 1'b0, v);
    check("ch4_after_ch6", v, 32'hFFFC);

    // Asynchronous reset mid-count: ch3 one-shot at count 5
    wr(3, 1'b1, 1);
    wr(3, 1'b0, 8);
    repeat (3) cycle(NCH'(8), 1'b0, 3, 1'b0, 0);
    #1;
    bus.we = 1'b0; bus.tick = '0; bus.ch = CH_W'(3); bus.reg_sel = 1'b0;
    #1;
    check("pre_rst_cnt", 32'(bus.rdata), 32'd5);
    check("pre_rst_out", 32'(bus.ch_out[3]), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_cnt", 32'(bus.rdata), 32'd0);
    check("async_rst_irq", 32'(bus.irq), 32'd0);
    check("async_rst_out", 32'(bus.ch_out), 32'd0);
    check("async_rst_cnt_out", 32'(bus.cnt_out), 32'd0);
    bus.reg_sel = 1'b1;
    #0.5;
    check("async_rst_mode", 32'(bus.rdata), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      w    = ($urandom_range(0, 4) == 0);
      c    = int'($urandom_range(0, 7));
      rsel = int'($urandom_range(0, 1));
      if (rsel == 1) d = $urandom_range(0, 15);
      else begin
        d = $urandom_range(0, 9);
        if (d == 9) d = $urandom_range(0, 65535);
      end
      cycle(NCH'($urandom), w, c, rsel == 1, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
